// File: rtl/cdb_arbiter_if.sv
// Bundle of the functional-unit request side and the common data bus broadcast
// side of the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int LABEL_W = 4,
    parameter int DATA_W  = 32,
    parameter int PTR_W   = 3
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*LABEL_W-1:0] req_label;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     BCEN;
    logic [LABEL_W-1:0]       BClabel;
    logic [DATA_W-1:0]        BCdata;
    logic [PTR_W-1:0]         grant_id;

    // Functional units and broadcast consumers.
    modport master (
        output req_valid, req_label, req_data,
        input  req_ready, BCEN, BClabel, BCdata, grant_id
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_label, req_data,
        output req_ready, BCEN, BClabel, BCdata, grant_id
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry result buffer per functional unit and a
// round-robin grant of the single broadcast bus per cycle.
module cdb_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LABEL_W = 4,
    parameter int DATA_W  = 32,
    parameter int PTR_W   = 3
) (
    input  logic         clk,
    input  logic         nRST,
    cdb_arbiter_if.slave bus
);
    logic [N_REQ-1:0]   buf_valid_r;
    logic [LABEL_W-1:0] buf_label_r [N_REQ];
    logic [DATA_W-1:0]  buf_data_r  [N_REQ];
    logic [PTR_W-1:0]   rr_ptr_r;

    logic               bcen_r;
    logic [LABEL_W-1:0] bclabel_r;
    logic [DATA_W-1:0]  bcdata_r;
    logic [PTR_W-1:0]   grant_id_r;

    logic [N_REQ-1:0]   grant_s;
    logic               win_s;
    logic [PTR_W-1:0]   win_id_s;
    logic [PTR_W-1:0]   rr_next_s;
    logic [LABEL_W-1:0] sel_label_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic [N_REQ-1:0]   accept_s;

    // Round-robin search over buffered entries only, starting at rr_ptr.
    always_comb begin
        logic [PTR_W:0]     idx;
        logic [N_REQ-1:0]   shifted;
        logic               hit;
        win_s    = 1'b0;
        win_id_s = {PTR_W{1'b0}};
        idx      = {(PTR_W+1){1'b0}};
        shifted  = {N_REQ{1'b0}};
        hit      = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx      = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
            idx      = (idx >= (PTR_W+1)'(N_REQ)) ? (idx - (PTR_W+1)'(N_REQ)) : idx;
            shifted  = buf_valid_r >> idx;
            hit      = ~win_s & shifted[0];
            win_id_s = hit ? idx[PTR_W-1:0] : win_id_s;
            win_s    = win_s | hit;
        end
        grant_s   = win_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_id_s) : {N_REQ{1'b0}};
        rr_next_s = (win_id_s == PTR_W'(N_REQ-1)) ? {PTR_W{1'b0}} : (win_id_s + {{(PTR_W-1){1'b0}}, 1'b1});
    end

    // Winner's buffered result, selected by one-hot grant.
    always_comb begin
        sel_label_s = {LABEL_W{1'b0}};
        sel_data_s  = {DATA_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_label_s = grant_s[i] ? buf_label_r[i] : sel_label_s;
            sel_data_s  = grant_s[i] ? buf_data_r[i]  : sel_data_s;
        end
    end

    // A granted buffer can be refilled on the same edge it is freed.
    always_comb begin
        req_ready_s = {N_REQ{nRST}} & (~buf_valid_r | grant_s);
        accept_s    = bus.req_valid & req_ready_s;
    end

    // Buffers, pointer and registered broadcast outputs.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            buf_valid_r <= {N_REQ{1'b0}};
            rr_ptr_r    <= {PTR_W{1'b0}};
            bcen_r      <= 1'b0;
            bclabel_r   <= {LABEL_W{1'b0}};
            bcdata_r    <= {DATA_W{1'b0}};
            grant_id_r  <= {PTR_W{1'b0}};
            for (int i = 0; i < N_REQ; i++) begin
                buf_label_r[i] <= {LABEL_W{1'b0}};
                buf_data_r[i]  <= {DATA_W{1'b0}};
            end
        end else begin
            bcen_r <= win_s;
            if (win_s) begin
                bclabel_r  <= sel_label_s;
                bcdata_r   <= sel_data_s;
                grant_id_r <= win_id_s;
                rr_ptr_r   <= rr_next_s;
            end else begin
                bclabel_r  <= bclabel_r;
                bcdata_r   <= bcdata_r;
                grant_id_r <= grant_id_r;
                rr_ptr_r   <= rr_ptr_r;
            end
            // Label 0 is a bus error: the handshake completes but nothing is stored.
            for (int i = 0; i < N_REQ; i++) begin
                if (accept_s[i] && (bus.req_label[i*LABEL_W +: LABEL_W] != {LABEL_W{1'b0}})) begin
                    buf_valid_r[i] <= 1'b1;
                    buf_label_r[i] <= bus.req_label[i*LABEL_W +: LABEL_W];
                    buf_data_r[i]  <= bus.req_data[i*DATA_W +: DATA_W];
                end else if (grant_s[i]) begin
                    buf_valid_r[i] <= 1'b0;
                end else begin
                    buf_valid_r[i] <= buf_valid_r[i];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.BCEN      = bcen_r;
    assign bus.BClabel   = bclabel_r;
    assign bus.BCdata    = bcdata_r;
    assign bus.grant_id  = grant_id_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the arbiter.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int LW = 4;
    localparam int DW = 32;
    localparam int PW = 3;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .LABEL_W(LW), .DATA_W(DW), .PTR_W(PW)) bus ();
    cdb_arbiter #(.N_REQ(N), .LABEL_W(LW), .DATA_W(DW), .PTR_W(PW)) dut (
        .clk  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit           mv [N];
    logic [LW-1:0] ml [N];
    logic [DW-1:0] md [N];
    int           mrr   = 0;
    bit           e_bcen = 1'b0;
    logic [LW-1:0] e_lab = '0;
    logic [DW-1:0] e_dat = '0;
    int           e_gid = 0;
    logic [N-1:0] e_ready;

    // Stimulus held by the bench until accepted
    logic [N-1:0]  sv = '0;
    logic [LW-1:0] sl [N];
    logic [DW-1:0] sd [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.req_valid = sv;
        for (int i = 0; i < N; i++) begin
            bus.req_label[i*LW +: LW] = sl[i];
            bus.req_data[i*DW +: DW]  = sd[i];
        end
    endtask

    function automatic int model_winner();
        int w = -1;
        for (int k = 0; k < N; k++) begin
            int j = (mrr + k) % N;
            if (w < 0 && mv[j]) w = j;
        end
        return w;
    endfunction

    // One clock: check ready before the edge, advance model, check outputs after.
    task automatic cycle();
        int w;
        drive();
        #1;
        w = model_winner();
        for (int i = 0; i < N; i++) e_ready[i] = nrst && (!mv[i] || i == w);
        check("req_ready", 64'(bus.req_ready), 64'(e_ready));
        @(posedge clk);
        if (!nrst) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            mrr = 0; e_bcen = 1'b0; e_lab = '0; e_dat = '0; e_gid = 0;
        end else begin
            e_bcen = (w >= 0);
            if (w >= 0) begin
                e_lab = ml[w]; e_dat = md[w]; e_gid = w;
                mrr = (w + 1) % N;
                mv[w] = 1'b0;
            end
            for (int i = 0; i < N; i++)
                if (sv[i] && e_ready[i] && sl[i] != '0) begin
                    mv[i] = 1'b1; ml[i] = sl[i]; md[i] = sd[i];
                end
        end
        #1;
        check("BCEN", 64'(bus.BCEN), 64'(e_bcen));
        check("BClabel", 64'(bus.BClabel), 64'(e_lab));
        check("BCdata", 64'(bus.BCdata), 64'(e_dat));
        check("grant_id", 64'(bus.grant_id), 64'(e_gid));
        check("rr_ptr", 64'(dut.rr_ptr_r), 64'(mrr));
    endtask

    task automatic idle(input int n);
        sv = '0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        idle(2);
        nrst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin sl[i] = '0; sd[i] = '0; end
        do_reset();
        check("rst_bcen", 64'(bus.BCEN), 64'd0);
        check("rst_grant", 64'(bus.grant_id), 64'd0);

        // Single request from unit 2
        sv = 4'b0100; sl[2] = 4'd5; sd[2] = 32'hDEADBEEF;
        cycle();
        idle(1);
        check("single_bcen", 64'(bus.BCEN), 64'd1);
        check("single_label", 64'(bus.BClabel), 64'd5);
        check("single_data", 64'(bus.BCdata), 64'hDEADBEEF);
        check("single_gid", 64'(bus.grant_id), 64'd2);
        idle(1);
        check("single_off", 64'(bus.BCEN), 64'd0);
        check("single_rr", 64'(dut.rr_ptr_r), 64'd3);

        // Full contention from rr_ptr 0
        do_reset();
        sv = 4'b1111;
        for (int i = 0; i < N; i++) begin sl[i] = LW'(i + 1); sd[i] = 32'h100 + 32'(i); end
        cycle();
        sv = '0;
        for (int k = 0; k < N; k++) begin
            cycle();
            check("cont_label", 64'(bus.BClabel), 64'(k + 1));
            check("cont_bcen", 64'(bus.BCEN), 64'd1);
        end
        check("cont_rr", 64'(dut.rr_ptr_r), 64'd0);

        // Round-robin wrap: move pointer to 3, then units 1 and 3
        sv = 4'b0100; sl[2] = 4'd7; sd[2] = 32'h7;
        cycle();
        idle(1);
        sv = 4'b1010; sl[1] = 4'd9; sd[1] = 32'h9; sl[3] = 4'd11; sd[3] = 32'hB;
        cycle();
        idle(1);
        check("wrap_first", 64'(bus.grant_id), 64'd3);
        idle(1);
        check("wrap_second", 64'(bus.grant_id), 64'd1);
        check("wrap_rr", 64'(dut.rr_ptr_r), 64'd2);

        // Back-to-back from unit 0
        for (int k = 0; k < 5; k++) begin
            sv = 4'b0001; sl[0] = LW'(6 + k); sd[0] = 32'hA0 + 32'(k);
            cycle();
            check("b2b_ready", 64'(bus.req_ready[0]), 64'd1);
            if (k > 0) check("b2b_label", 64'(bus.BClabel), 64'(5 + k));
        end
        idle(1);
        check("b2b_last", 64'(bus.BClabel), 64'd10);
        idle(1);
        check("b2b_off", 64'(bus.BCEN), 64'd0);

        // Backpressure: all units continuously valid
        sv = 4'b1111;
        for (int i = 0; i < N; i++) begin sl[i] = LW'(i + 1); sd[i] = 32'(i); end
        for (int k = 0; k < 12; k++) begin
            cycle();
            for (int i = 0; i < N; i++)
                if (e_ready[i]) begin sl[i] = LW'($urandom_range(1, 15)); sd[i] = $urandom; end
        end
        idle(N + 1);

        // Label 0 from unit 1 is swallowed
        sv = 4'b0010; sl[1] = 4'd0; sd[1] = 32'h55;
        cycle();
        idle(1);
        check("lbl0_bcen", 64'(bus.BCEN), 64'd0);
        idle(1);
        check("lbl0_bcen2", 64'(bus.BCEN), 64'd0);

        // Reset mid-operation with three buffers valid
        sv = 4'b0111;
        for (int i = 0; i < 3; i++) begin sl[i] = LW'(i + 12); sd[i] = 32'hC0 + 32'(i); end
        cycle();
        sv = '0; nrst = 1'b0;
        cycle();
        check("mid_bcen", 64'(bus.BCEN), 64'd0);
        check("mid_label", 64'(bus.BClabel), 64'd0);
        check("mid_data", 64'(bus.BCdata), 64'd0);
        check("mid_gid", 64'(bus.grant_id), 64'd0);
        check("mid_rr", 64'(dut.rr_ptr_r), 64'd0);
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("mid_quiet", 64'(bus.BCEN), 64'd0);
        end

        // Random traffic with hold-until-accepted and occasional reset
        for (int k = 0; k < 3000; k++) begin
            nrst = ($urandom_range(0, 199) != 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (sv[i] && e_ready[i]) sv[i] = 1'b0;
                if (!sv[i] && $urandom_range(0, 2) == 0) begin
                    sv[i] = 1'b1;
                    sl[i] = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 15));
                    sd[i] = $urandom;
                end
            end
        end
        nrst = 1'b1;
        idle(N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
